// File: rtl/stopwatch_pkg.sv
// Shared types, widths and BCD helpers for the stopwatch core.
package stopwatch_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam int unsigned MAX_DIGITS = 8;

  localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [BCD_W-1:0] BCD_MAX6 = 4'd5;

  // Control states: SATURATED is only reachable when wrapping is disabled.
  typedef enum logic [1:0] {
    ST_STOPPED   = 2'd0,
    ST_RUNNING   = 2'd1,
    ST_SATURATED = 2'd2
  } sw_state_e;

  // One-cycle press events coming out of the debouncers.
  typedef struct packed {
    logic start_stop;
    logic clear;
    logic lap;
  } btn_ev_t;

  // Terminal value of a single digit (5 for tens-of-seconds style digits).
  function automatic logic [BCD_W-1:0] bcd_digit_max(input logic mod6);
    return mod6 ? BCD_MAX6 : BCD_MAX;
  endfunction

  // Full-scale BCD value for n digits, digit 0 in the low nibble.
  function automatic logic [BCD_W*MAX_DIGITS-1:0] bcd_full(input int unsigned n,
                                                           input logic [MAX_DIGITS-1:0] mask);
    logic [BCD_W*MAX_DIGITS-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if (i < n) begin
        v[i*BCD_W +: BCD_W] = bcd_digit_max(mask[i]);
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/stopwatch_lap_if.sv
// Button inputs and display/status outputs of the stopwatch core.
interface stopwatch_lap_if #(
  parameter int unsigned N_DIGITS = 4
);
  import stopwatch_pkg::*;

  logic                      start_stop;
  logic                      clear;
  logic                      lap;
  logic [BCD_W*N_DIGITS-1:0] digits;
  logic                      running;
  logic                      lap_hold;
  logic                      overflow;

  // Board / bench side: drives the raw active-low buttons, watches the display.
  modport master (
    output start_stop, clear, lap,
    input  digits, running, lap_hold, overflow
  );

  // Core side.
  modport slave (
    input  start_stop, clear, lap,
    output digits, running, lap_hold, overflow
  );

endinterface

// File: rtl/button_debounce.sv
// Synchroniser + stability-counter debouncer for one active-low push-button.
// press_c pulses for one cycle when the accepted level goes from released to pressed.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 320_000
) (
  input  logic clk,
  input  logic rstb,
  input  logic btn_n_i,
  output logic press_c
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count consecutive samples that disagree with the accepted level; flip on the last one.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      level_d = sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Press is decoded from the flip about to happen, so it aligns with the level update.
  assign press_c = level_q & ~level_d;

  // Synchroniser, accepted level and stability counter.
  always_ff @(posedge clk) begin
    if (rstb) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/stopwatch_lap.sv
// BCD stopwatch core: debounced buttons, tick prescaler, run/stop/saturate control,
// per-digit BCD cascade with optional mod-6 digits, and a lap display freeze.
module stopwatch_lap
  import stopwatch_pkg::*;
#(
  parameter int unsigned           CLK_HZ       = 32_000_000,
  parameter int unsigned           TICK_HZ      = 100,
  parameter int unsigned           N_DIGITS     = 4,
  parameter logic [MAX_DIGITS-1:0] MOD6_MASK    = '0,
  parameter int unsigned           WRAP         = 1,
  parameter int unsigned           DEBOUNCE_CYC = 320_000
) (
  input  logic           clk,
  input  logic           rstb,
  stopwatch_lap_if.slave bus
);

  localparam int unsigned DW       = BCD_W * N_DIGITS;
  localparam int unsigned PRESCALE = CLK_HZ / TICK_HZ;
  localparam int unsigned PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [BCD_W*MAX_DIGITS-1:0] FULL_ALL = bcd_full(N_DIGITS, MOD6_MASK);
  localparam logic [DW-1:0] FULL = FULL_ALL[DW-1:0];

  sw_state_e       state_q;
  sw_state_e       state_d;
  btn_ev_t         ev_c;
  logic            ss_ev_c;
  logic            clr_ev_c;
  logic            lap_ev_c;

  logic [PS_W-1:0] ps_q;
  logic [PS_W-1:0] ps_d;
  logic [DW-1:0]   count_q;
  logic [DW-1:0]   count_d;
  logic [DW-1:0]   count_inc;
  logic [DW-1:0]   disp_q;
  logic [DW-1:0]   disp_d;
  logic            running_q;
  logic            running_d;
  logic            lap_hold_q;
  logic            lap_hold_d;
  logic            overflow_q;
  logic            overflow_d;

  logic            run_c;
  logic            tick_c;
  logic            full_tick_c;
  logic            sat_tick_c;
  logic            capture_c;

  // Button front ends.
  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_start_stop (
    .clk     (clk),
    .rstb    (rstb),
    .btn_n_i (bus.start_stop),
    .press_c (ss_ev_c)
  );

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_clear (
    .clk     (clk),
    .rstb    (rstb),
    .btn_n_i (bus.clear),
    .press_c (clr_ev_c)
  );

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_lap (
    .clk     (clk),
    .rstb    (rstb),
    .btn_n_i (bus.lap),
    .press_c (lap_ev_c)
  );

  assign ev_c = {ss_ev_c, clr_ev_c, lap_ev_c};

  // Control state register.
  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q <= ST_STOPPED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: start_stop toggles; saturation locks out start_stop until a clear.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOPPED: begin
        if (ev_c.start_stop) state_d = ST_RUNNING;
      end
      ST_RUNNING: begin
        if (ev_c.start_stop) begin
          state_d = ST_STOPPED;
        end else if (sat_tick_c && !ev_c.clear) begin
          state_d = ST_SATURATED;
        end
      end
      ST_SATURATED: begin
        if (ev_c.clear) state_d = ev_c.start_stop ? ST_RUNNING : ST_STOPPED;
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  // State decode: tick generation, full-scale detection and lap capture qualifier.
  always_comb begin
    run_c       = (state_q == ST_RUNNING);
    tick_c      = run_c && (ps_q == PS_LAST);
    full_tick_c = tick_c && (count_q == FULL);
    sat_tick_c  = full_tick_c && (WRAP == 0);
    capture_c   = run_c && ev_c.lap && !ev_c.clear && !lap_hold_q;
  end

  // BCD cascade: each digit increments on its carry-in and passes a carry when at its terminal value.
  for (genvar g = 0; g < int'(N_DIGITS); g++) begin : g_digit
    localparam logic [BCD_W-1:0] DMAX = bcd_digit_max(MOD6_MASK[g]);
    logic [BCD_W-1:0] cur;
    logic             at_max;
    logic             cin;

    assign cur    = count_q[g*BCD_W +: BCD_W];
    assign at_max = (cur == DMAX);

    if (g == 0) begin : g_first
      assign cin = tick_c;
    end else begin : g_next
      assign cin = g_digit[g-1].cin & g_digit[g-1].at_max;
    end

    assign count_inc[g*BCD_W +: BCD_W] = !cin ? cur : (at_max ? '0 : cur + BCD_W'(1));
  end

  // Datapath next values; clear wins over tick and lap in the same cycle.
  always_comb begin
    ps_d       = ps_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    lap_hold_d = lap_hold_q;

    if (ev_c.clear) begin
      ps_d       = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      lap_hold_d = 1'b0;
    end else begin
      if (tick_c) begin
        ps_d = '0;
      end else if (run_c) begin
        ps_d = ps_q + PS_W'(1);
      end

      if (!sat_tick_c) begin
        count_d = count_inc;
      end

      if (full_tick_c) begin
        overflow_d = 1'b1;
      end

      if (ev_c.lap) begin
        if (lap_hold_q) begin
          lap_hold_d = 1'b0;
        end else if (run_c) begin
          lap_hold_d = 1'b1;
        end
      end
    end

    running_d = (state_d == ST_RUNNING);
    // While held the display keeps its value; a fresh capture takes the post-tick count.
    disp_d    = (lap_hold_d && !capture_c) ? disp_q : count_d;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rstb) begin
      ps_q       <= '0;
      count_q    <= '0;
      disp_q     <= '0;
      running_q  <= 1'b0;
      lap_hold_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      ps_q       <= ps_d;
      count_q    <= count_d;
      disp_q     <= disp_d;
      running_q  <= running_d;
      lap_hold_q <= lap_hold_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.digits   = disp_q;
  assign bus.running  = running_q;
  assign bus.lap_hold = lap_hold_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Directed bench for stopwatch_lap: four instances cover the default wrap build,
// two-digit wrap and saturate builds, and a prescale-1 mod-6 build for priority cases.
module tb_stopwatch_lap;

  logic        clk = 1'b0;
  logic        rstb;
  logic        ss_n  [4];
  logic        clr_n [4];
  logic        lap_n [4];
  logic [15:0] dig   [4];
  logic        run   [4];
  logic        hold  [4];
  logic        ovf   [4];
  int          errors = 0;
  int          checks = 0;

  stopwatch_lap_if #(.N_DIGITS(4)) if0 ();
  stopwatch_lap_if #(.N_DIGITS(2)) if1 ();
  stopwatch_lap_if #(.N_DIGITS(2)) if2 ();
  stopwatch_lap_if #(.N_DIGITS(4)) if3 ();

  assign if0.start_stop = ss_n[0];
  assign if0.clear      = clr_n[0];
  assign if0.lap        = lap_n[0];
  assign if1.start_stop = ss_n[1];
  assign if1.clear      = clr_n[1];
  assign if1.lap        = lap_n[1];
  assign if2.start_stop = ss_n[2];
  assign if2.clear      = clr_n[2];
  assign if2.lap        = lap_n[2];
  assign if3.start_stop = ss_n[3];
  assign if3.clear      = clr_n[3];
  assign if3.lap        = lap_n[3];

  assign dig[0]  = if0.digits;
  assign dig[1]  = {8'h00, if1.digits};
  assign dig[2]  = {8'h00, if2.digits};
  assign dig[3]  = if3.digits;
  assign run[0]  = if0.running;
  assign run[1]  = if1.running;
  assign run[2]  = if2.running;
  assign run[3]  = if3.running;
  assign hold[0] = if0.lap_hold;
  assign hold[1] = if1.lap_hold;
  assign hold[2] = if2.lap_hold;
  assign hold[3] = if3.lap_hold;
  assign ovf[0]  = if0.overflow;
  assign ovf[1]  = if1.overflow;
  assign ovf[2]  = if2.overflow;
  assign ovf[3]  = if3.overflow;

  stopwatch_lap #(.CLK_HZ(1000), .TICK_HZ(100), .N_DIGITS(4), .MOD6_MASK(8'h00),
                  .WRAP(1), .DEBOUNCE_CYC(4)) u_main (.clk(clk), .rstb(rstb), .bus(if0));
  stopwatch_lap #(.CLK_HZ(1000), .TICK_HZ(100), .N_DIGITS(2), .MOD6_MASK(8'h00),
                  .WRAP(1), .DEBOUNCE_CYC(4)) u_wrap (.clk(clk), .rstb(rstb), .bus(if1));
  stopwatch_lap #(.CLK_HZ(1000), .TICK_HZ(100), .N_DIGITS(2), .MOD6_MASK(8'h00),
                  .WRAP(0), .DEBOUNCE_CYC(4)) u_sat (.clk(clk), .rstb(rstb), .bus(if2));
  stopwatch_lap #(.CLK_HZ(1000), .TICK_HZ(1000), .N_DIGITS(4), .MOD6_MASK(8'h08),
                  .WRAP(1), .DEBOUNCE_CYC(4)) u_m6 (.clk(clk), .rstb(rstb), .bus(if3));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input int k, input int b, input logic v);
    case (b)
      0:       ss_n[k]  = v;
      1:       clr_n[k] = v;
      default: lap_n[k] = v;
    endcase
  endtask

  task automatic press(input int k, input int b);
    set_btn(k, b, 1'b0);
    cyc(10);
    set_btn(k, b, 1'b1);
    cyc(10);
  endtask

  // Step until running matches want (bounded); lat = edges since the call.
  task automatic wait_run(input int k, input logic want, output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      if (run[k] === want) begin
        lat = i;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstb = 1'b1;
    cyc(2);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({dig[k], run[k], hold[k], ovf[k]} !== 19'h0) begin
        errors++;
        $display("FAIL reset[%0d]: got %h, expected %h", k, {dig[k], run[k], hold[k], ovf[k]}, 19'h0);
      end
    end
    rstb = 1'b0;
    cyc(1);
  endtask

  task automatic test_debounce();
    int lat;
    bit ok;
    for (int i = 0; i < 5; i++) begin
      ss_n[0] = 1'b0;
      cyc(3);
      ss_n[0] = 1'b1;
      cyc(3);
    end
    cyc(10);
    checks++;
    if (run[0] !== 1'b0) begin
      errors++;
      $display("FAIL bounce_ignored: got running=%b, expected 0", run[0]);
    end
    ss_n[0] = 1'b0;
    wait_run(0, 1'b1, lat, ok);
    checks++;
    if (!ok || lat < 5 || lat > 7) begin
      errors++;
      $display("FAIL press_latency: got %0d cycles (seen=%0d), expected 5..7", lat, ok);
    end
    cyc(10 - lat);
    ss_n[0] = 1'b1;
    cyc(20);
    checks++;
    if (run[0] !== 1'b1) begin
      errors++;
      $display("FAIL release_no_event: got running=%b, expected 1", run[0]);
    end
    press(0, 0);
    press(0, 1);
    checks++;
    if ({dig[0], run[0], ovf[0]} !== {16'h0000, 2'b00}) begin
      errors++;
      $display("FAIL stop_clear: got %h, expected %h", {dig[0], run[0], ovf[0]}, {16'h0000, 2'b00});
    end
  endtask

  task automatic test_count();
    int lat;
    bit ok;
    ss_n[0] = 1'b0;
    wait_run(0, 1'b1, lat, ok);
    cyc(8);
    ss_n[0] = 1'b1;
    cyc(1222);
    checks++;
    if ({dig[0], run[0]} !== {16'h0123, 1'b1} || !ok) begin
      errors++;
      $display("FAIL count_1230: got %h (start seen=%0d), expected %h", {dig[0], run[0]}, ok, {16'h0123, 1'b1});
    end
    ss_n[0] = 1'b0;
    wait_run(0, 1'b0, lat, ok);
    cyc(4);
    ss_n[0] = 1'b1;
    cyc(496);
    checks++;
    if ({dig[0], run[0]} !== {16'h0123, 1'b0} || !ok) begin
      errors++;
      $display("FAIL stopped_hold: got %h (stop seen=%0d), expected %h", {dig[0], run[0]}, ok, {16'h0123, 1'b0});
    end
    ss_n[0] = 1'b0;
    wait_run(0, 1'b1, lat, ok);
    cyc(3);
    checks++;
    if (dig[0] !== 16'h0123 || !ok) begin
      errors++;
      $display("FAIL restart_before_tick: got %h (restart seen=%0d), expected 0123", dig[0], ok);
    end
    cyc(1);
    checks++;
    if (dig[0] !== 16'h0124) begin
      errors++;
      $display("FAIL restart_tick: got %h, expected 0124", dig[0]);
    end
    ss_n[0] = 1'b1;
    cyc(10);
    press(0, 0);
    press(0, 1);
  endtask

  task automatic test_lap();
    int lat;
    bit ok;
    ss_n[0] = 1'b0;
    wait_run(0, 1'b1, lat, ok);
    cyc(8);
    ss_n[0] = 1'b1;
    cyc(491);
    lap_n[0] = 1'b0;
    cyc(10);
    lap_n[0] = 1'b1;
    checks++;
    if ({dig[0], hold[0]} !== {16'h0050, 1'b1} || !ok) begin
      errors++;
      $display("FAIL lap_capture: got %h (start seen=%0d), expected %h", {dig[0], hold[0]}, ok, {16'h0050, 1'b1});
    end
    cyc(90);
    checks++;
    if ({dig[0], hold[0], run[0]} !== {16'h0050, 2'b11}) begin
      errors++;
      $display("FAIL lap_frozen: got %h, expected %h", {dig[0], hold[0], run[0]}, {16'h0050, 2'b11});
    end
    cyc(100);
    lap_n[0] = 1'b0;
    cyc(10);
    lap_n[0] = 1'b1;
    checks++;
    if ({dig[0], hold[0]} !== {16'h0070, 1'b0}) begin
      errors++;
      $display("FAIL lap_release: got %h, expected %h", {dig[0], hold[0]}, {16'h0070, 1'b0});
    end
    press(0, 0);
    press(0, 2);
    checks++;
    if ({dig[0], hold[0], run[0]} !== {16'h0071, 2'b00}) begin
      errors++;
      $display("FAIL lap_when_stopped: got %h, expected %h", {dig[0], hold[0], run[0]}, {16'h0071, 2'b00});
    end
    press(0, 1);
  endtask

  task automatic test_wrap();
    int lat;
    bit ok;
    ss_n[1] = 1'b0;
    wait_run(1, 1'b1, lat, ok);
    cyc(8);
    ss_n[1] = 1'b1;
    cyc(991);
    checks++;
    if ({dig[1], ovf[1]} !== {16'h0099, 1'b0} || !ok) begin
      errors++;
      $display("FAIL wrap_full: got %h (start seen=%0d), expected %h", {dig[1], ovf[1]}, ok, {16'h0099, 1'b0});
    end
    cyc(1);
    checks++;
    if ({dig[1], run[1], ovf[1]} !== {16'h0000, 2'b11}) begin
      errors++;
      $display("FAIL wrap_roll: got %h, expected %h", {dig[1], run[1], ovf[1]}, {16'h0000, 2'b11});
    end
    press(1, 0);
    press(1, 1);
    checks++;
    if ({dig[1], ovf[1]} !== {16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL wrap_clear: got %h, expected %h", {dig[1], ovf[1]}, {16'h0000, 1'b0});
    end
  endtask

  task automatic test_saturate();
    int lat;
    bit ok;
    ss_n[2] = 1'b0;
    wait_run(2, 1'b1, lat, ok);
    cyc(8);
    ss_n[2] = 1'b1;
    cyc(991);
    cyc(1);
    checks++;
    if ({dig[2], run[2], ovf[2]} !== {16'h0099, 2'b01} || !ok) begin
      errors++;
      $display("FAIL sat_hold: got %h (start seen=%0d), expected %h", {dig[2], run[2], ovf[2]}, ok, {16'h0099, 2'b01});
    end
    press(2, 0);
    checks++;
    if ({dig[2], run[2]} !== {16'h0099, 1'b0}) begin
      errors++;
      $display("FAIL sat_ignore_start: got %h, expected %h", {dig[2], run[2]}, {16'h0099, 1'b0});
    end
    press(2, 1);
    checks++;
    if ({dig[2], run[2], ovf[2]} !== {16'h0000, 2'b00}) begin
      errors++;
      $display("FAIL sat_clear: got %h, expected %h", {dig[2], run[2], ovf[2]}, {16'h0000, 2'b00});
    end
    press(2, 0);
    checks++;
    if (run[2] !== 1'b1) begin
      errors++;
      $display("FAIL sat_restart: got running=%b, expected 1", run[2]);
    end
  endtask

  task automatic test_mod6_priority();
    int lat;
    bit ok;
    ss_n[3] = 1'b0;
    wait_run(3, 1'b1, lat, ok);
    cyc(8);
    ss_n[3] = 1'b1;
    cyc(5991);
    checks++;
    if ({dig[3], ovf[3]} !== {16'h5999, 1'b0} || !ok) begin
      errors++;
      $display("FAIL mod6_full: got %h (start seen=%0d), expected %h", {dig[3], ovf[3]}, ok, {16'h5999, 1'b0});
    end
    cyc(1);
    checks++;
    if ({dig[3], run[3], ovf[3]} !== {16'h0000, 2'b11}) begin
      errors++;
      $display("FAIL mod6_roll: got %h, expected %h", {dig[3], run[3], ovf[3]}, {16'h0000, 2'b11});
    end
    lap_n[3] = 1'b0;
    cyc(6);
    checks++;
    if ({dig[3], hold[3]} !== {16'h0006, 1'b1}) begin
      errors++;
      $display("FAIL m6_lap_capture: got %h, expected %h", {dig[3], hold[3]}, {16'h0006, 1'b1});
    end
    cyc(4);
    lap_n[3] = 1'b1;
    cyc(10);
    clr_n[3] = 1'b0;
    lap_n[3] = 1'b0;
    cyc(6);
    checks++;
    if ({dig[3], hold[3], run[3], ovf[3]} !== {16'h0000, 3'b010}) begin
      errors++;
      $display("FAIL clear_lap_held: got %h, expected %h", {dig[3], hold[3], run[3], ovf[3]}, {16'h0000, 3'b010});
    end
    cyc(1);
    checks++;
    if (dig[3] !== 16'h0001) begin
      errors++;
      $display("FAIL clear_then_tick: got %h, expected 0001", dig[3]);
    end
    clr_n[3] = 1'b1;
    lap_n[3] = 1'b1;
    cyc(10);
    clr_n[3] = 1'b0;
    lap_n[3] = 1'b0;
    cyc(6);
    checks++;
    if ({dig[3], hold[3]} !== {16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL clear_beats_capture: got %h, expected %h", {dig[3], hold[3]}, {16'h0000, 1'b0});
    end
    clr_n[3] = 1'b1;
    lap_n[3] = 1'b1;
    cyc(10);
    clr_n[3] = 1'b0;
    ss_n[3]  = 1'b0;
    cyc(6);
    checks++;
    if ({dig[3], run[3]} !== {16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL clear_and_stop: got %h, expected %h", {dig[3], run[3]}, {16'h0000, 1'b0});
    end
    clr_n[3] = 1'b1;
    ss_n[3]  = 1'b1;
    cyc(10);
  endtask

  task automatic test_reset_midrun();
    int lat;
    bit ok;
    ss_n[0] = 1'b0;
    wait_run(0, 1'b1, lat, ok);
    cyc(8);
    ss_n[0] = 1'b1;
    cyc(30);
    checks++;
    if ({dig[0], run[0]} !== {16'h0003, 1'b1} || !ok) begin
      errors++;
      $display("FAIL pre_reset_count: got %h (start seen=%0d), expected %h", {dig[0], run[0]}, ok, {16'h0003, 1'b1});
    end
    rstb = 1'b1;
    cyc(1);
    rstb = 1'b0;
    checks++;
    if ({dig[0], run[0], hold[0], ovf[0]} !== 19'h0) begin
      errors++;
      $display("FAIL midrun_reset: got %h, expected %h", {dig[0], run[0], hold[0], ovf[0]}, 19'h0);
    end
    cyc(20);
    checks++;
    if ({dig[0], run[0]} !== 17'h0) begin
      errors++;
      $display("FAIL after_reset_idle: got %h, expected %h", {dig[0], run[0]}, 17'h0);
    end
  endtask

  initial begin
    rstb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ss_n[k]  = 1'b1;
      clr_n[k] = 1'b1;
      lap_n[k] = 1'b1;
    end
    test_reset();
    test_debounce();
    test_count();
    test_lap();
    test_wrap();
    test_saturate();
    test_mod6_priority();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
